itcm_ctrl: RTL and testbench

Instruction TCM controller: the memory-side responder of the fetch interface driven by the ifu. It serves one 32-bit aligned word per enabled fetch with one-cycle latency. It also owns a word-stream program loader that fills the memory while holding the core in reset. It releases the core into execution only after a load completes or an explicit run command arrives.

---
 rtl/itcm_ctrl_if.sv | 44 ++++
 rtl/itcm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_itcm_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/itcm_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : itcm_ctrl_if                                                  |
// | Purpose  : Bus bundle between the ITCM controller and its two clients:   |
// |            the ifu fetch port and the word-stream program loader.        |
// | Signals  : ifu_flash_i_pc / ifu_flash_i_enable  fetch request            |
// |            itcm_ifu_o_ir / itcm_o_fetch_err     fetch response           |
// |            ld_i_start / ld_i_run                loader commands          |
// |            ld_i_valid / ld_i_data / ld_i_last   loader word stream       |
// |            ld_o_ready                           loader back-pressure     |
// | Modports : master (ifu + loader side), slave (controller side)           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
interface itcm_ctrl_if #(
   parameter int XLEN    = 32,
   parameter int PC_SIZE = 32
);
   logic [PC_SIZE-1:0] ifu_flash_i_pc;
   logic               ifu_flash_i_enable;
   logic [XLEN-1:0]    itcm_ifu_o_ir;
   logic               itcm_o_fetch_err;

   logic               ld_i_start;
   logic               ld_i_run;
   logic               ld_i_valid;
   logic [XLEN-1:0]    ld_i_data;
   logic               ld_i_last;
   logic               ld_o_ready;

   modport master (
      output ifu_flash_i_pc, ifu_flash_i_enable,
      output ld_i_start, ld_i_run, ld_i_valid, ld_i_data, ld_i_last,
      input  itcm_ifu_o_ir, itcm_o_fetch_err, ld_o_ready
   );

   modport slave (
      input  ifu_flash_i_pc, ifu_flash_i_enable,
      input  ld_i_start, ld_i_run, ld_i_valid, ld_i_data, ld_i_last,
      output itcm_ifu_o_ir, itcm_o_fetch_err, ld_o_ready
   );
endinterface
`default_nettype wire

// File: rtl/itcm_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : itcm_ctrl                                                     |
// | Purpose  : Instruction TCM controller. Serves one aligned word per       |
// |            enabled fetch with one-cycle latency, and owns a word-stream  |
// |            program loader that fills the memory while the core is held   |
// |            in reset. The core is released after a completed load or an   |
// |            explicit run command.                                         |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            bus                 itcm_ctrl_if.slave (fetch + loader)       |
// |            itcm_o_core_rst_n   core reset, high only while running       |
// |            itcm_o_ld_done      last load completed                       |
// |            itcm_o_ld_ovf       sticky load-pointer wrap flag             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module itcm_ctrl #(
   parameter int ITCM_AW = 12,
   parameter int XLEN    = 32,
   parameter int PC_SIZE = 32
) (
   input  wire         clk,
   input  wire         rst_n,
   itcm_ctrl_if.slave  bus,
   output logic        itcm_o_core_rst_n,
   output logic        itcm_o_ld_done,
   output logic        itcm_o_ld_ovf
);

   localparam int               DEPTH   = 2 ** ITCM_AW;
   localparam logic [XLEN-1:0]  NOP     = XLEN'(32'h0000_0013);
   localparam logic [ITCM_AW-1:0] PTR_ONE = ITCM_AW'(1);
   localparam logic [ITCM_AW-1:0] PTR_MAX = '1;

   // Each state's externally visible meaning is carried by exactly one bit,
   // so ld_o_ready and core reset come straight off a flop and cannot glitch.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic [ITCM_AW-1:0]  ptr_q, ptr_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic [XLEN-1:0]     ir_q, ir_d;
   logic                err_q, err_d;
   logic                mem_we;

   logic [XLEN-1:0]     mem_q [DEPTH];

   logic                fetch_en;
   logic                fetch_in_range;
   logic [ITCM_AW-1:0]  fetch_idx;
   logic                unused_pc_bits;

   // Byte offset within the word is irrelevant: the ifu picks the half.
   assign unused_pc_bits = ^bus.ifu_flash_i_pc[1:0];

   assign fetch_en       = (state_q == ST_RUN) && bus.ifu_flash_i_enable;
   assign fetch_in_range = (bus.ifu_flash_i_pc[PC_SIZE-1:ITCM_AW+2] == '0);
   assign fetch_idx      = bus.ifu_flash_i_pc[ITCM_AW+1:2];

   //---------------------------------------------------------------------------
   // Next-state / loader control
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      mem_we  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // start has priority over run when both pulse together
            if (bus.ld_i_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
               ovf_d   = 1'b0;
               done_d  = 1'b0;
            end else if (bus.ld_i_run) begin
               state_d = ST_RUN;
            end
         end

         ST_LOAD: begin
            if (bus.ld_i_start) begin
               // restart: the beat presented this cycle is dropped
               ptr_d  = '0;
               ovf_d  = 1'b0;
               done_d = 1'b0;
            end else if (bus.ld_i_valid) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + PTR_ONE;
               if (bus.ld_i_last) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else if (ptr_q == PTR_MAX) begin
                  ovf_d = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (bus.ld_i_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
               ovf_d   = 1'b0;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Fetch response: hold the last word when no fetch is taken
   //---------------------------------------------------------------------------
   always_comb begin
      ir_d  = ir_q;
      err_d = 1'b0;
      if (fetch_en) begin
         if (fetch_in_range) begin
            ir_d = mem_q[fetch_idx];
         end else begin
            ir_d  = NOP;
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ir_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
      end
   end

   // Storage array is deliberately not reset; a reset mid-load keeps
   // whatever words were already written.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[ptr_q] <= bus.ld_i_data;
      end
   end

   assign bus.itcm_ifu_o_ir    = ir_q;
   assign bus.itcm_o_fetch_err = err_q;
   assign bus.ld_o_ready       = state_q[0];
   assign itcm_o_core_rst_n    = state_q[1];
   assign itcm_o_ld_done       = done_q;
   assign itcm_o_ld_ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_itcm_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_itcm_ctrl                                                  |
// | Purpose  : Self-checking bench for itcm_ctrl. Two instances: default     |
// |            address width, and a 4-word memory for pointer wrap.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_itcm_ctrl;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;

   logic clk;
   logic rst_n;

   itcm_ctrl_if #(.XLEN(32), .PC_SIZE(32)) bus0 ();
   itcm_ctrl_if #(.XLEN(32), .PC_SIZE(32)) bus1 ();

   logic core0, done0, ovf0;
   logic core1, done1, ovf1;

   itcm_ctrl #(.ITCM_AW(12), .XLEN(32), .PC_SIZE(32)) u_dut0 (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus               (bus0.slave),
      .itcm_o_core_rst_n (core0),
      .itcm_o_ld_done    (done0),
      .itcm_o_ld_ovf     (ovf0)
   );

   itcm_ctrl #(.ITCM_AW(2), .XLEN(32), .PC_SIZE(32)) u_dut1 (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus               (bus1.slave),
      .itcm_o_core_rst_n (core1),
      .itcm_o_ld_done    (done1),
      .itcm_o_ld_ovf     (ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Behavioural model: one mode per instance, memory as a sparse map
   //---------------------------------------------------------------------------
   int          m_mode [2];
   int          m_ptr  [2];
   logic        m_done [2];
   logic        m_ovf  [2];
   logic        m_err  [2];
   logic [31:0] m_ir   [2];
   logic [31:0] m_mem  [int];

   function automatic logic [31:0] mem_rd(input int id, input int a);
      if (m_mem.exists(id * 100000 + a)) return m_mem[id * 100000 + a];
      return 'x;
   endfunction

   task automatic model_reset(input int id);
      m_mode[id] = M_IDLE;
      m_ptr[id]  = 0;
      m_done[id] = 1'b0;
      m_ovf[id]  = 1'b0;
      m_err[id]  = 1'b0;
      m_ir[id]   = 32'h0;
   endtask

   task automatic model_step(input int id, input int aw,
                             input logic [31:0] pc, input logic en,
                             input logic start, input logic run,
                             input logic valid, input logic [31:0] data,
                             input logic last);
      int depth;
      depth = 1 << aw;
      m_err[id] = 1'b0;
      if (m_mode[id] == M_RUN && en) begin
         if ((pc >> (aw + 2)) == 32'd0) begin
            m_ir[id] = mem_rd(id, int'(pc >> 2));
         end else begin
            m_ir[id]  = 32'h0000_0013;
            m_err[id] = 1'b1;
         end
      end
      if (start) begin
         m_mode[id] = M_LOAD;
         m_ptr[id]  = 0;
         m_ovf[id]  = 1'b0;
         m_done[id] = 1'b0;
      end else if (m_mode[id] == M_IDLE && run) begin
         m_mode[id] = M_RUN;
      end else if (m_mode[id] == M_LOAD && valid) begin
         m_mem[id * 100000 + m_ptr[id]] = data;
         if (last) begin
            m_mode[id] = M_RUN;
            m_done[id] = 1'b1;
         end else if (m_ptr[id] == depth - 1) begin
            m_ovf[id] = 1'b1;
         end
         m_ptr[id] = (m_ptr[id] + 1) % depth;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset(0);
      else model_step(0, 12, bus0.ifu_flash_i_pc, bus0.ifu_flash_i_enable,
                      bus0.ld_i_start, bus0.ld_i_run, bus0.ld_i_valid,
                      bus0.ld_i_data, bus0.ld_i_last);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset(1);
      else model_step(1, 2, bus1.ifu_flash_i_pc, bus1.ifu_flash_i_enable,
                      bus1.ld_i_start, bus1.ld_i_run, bus1.ld_i_valid,
                      bus1.ld_i_data, bus1.ld_i_last);
   end

   // Compare process, sampled on the falling edge
   always @(negedge clk) begin
      if (!$isunknown(m_ir[0])) check("ir0", bus0.itcm_ifu_o_ir, m_ir[0]);
      check("err0",   32'(bus0.itcm_o_fetch_err), 32'(m_err[0]));
      check("ready0", 32'(bus0.ld_o_ready), 32'(m_mode[0] == M_LOAD));
      check("core0",  32'(core0), 32'(m_mode[0] == M_RUN));
      check("done0",  32'(done0), 32'(m_done[0]));
      check("ovf0",   32'(ovf0), 32'(m_ovf[0]));
      if (!$isunknown(m_ir[1])) check("ir1", bus1.itcm_ifu_o_ir, m_ir[1]);
      check("err1",   32'(bus1.itcm_o_fetch_err), 32'(m_err[1]));
      check("ready1", 32'(bus1.ld_o_ready), 32'(m_mode[1] == M_LOAD));
      check("core1",  32'(core1), 32'(m_mode[1] == M_RUN));
      check("done1",  32'(done1), 32'(m_done[1]));
      check("ovf1",   32'(ovf1), 32'(m_ovf[1]));
   end

   //---------------------------------------------------------------------------
   // Directed stimulus with literal expectations
   //---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus0.ifu_flash_i_pc = '0; bus0.ifu_flash_i_enable = 1'b0;
      bus0.ld_i_start = 1'b0;   bus0.ld_i_run = 1'b0;
      bus0.ld_i_valid = 1'b0;   bus0.ld_i_data = '0; bus0.ld_i_last = 1'b0;
      bus1.ifu_flash_i_pc = '0; bus1.ifu_flash_i_enable = 1'b0;
      bus1.ld_i_start = 1'b0;   bus1.ld_i_run = 1'b0;
      bus1.ld_i_valid = 1'b0;   bus1.ld_i_data = '0; bus1.ld_i_last = 1'b0;
   endtask

   logic [31:0] prog [4];
   logic [31:0] wrap_exp [4];

   initial begin
      prog[0] = 32'h0000_0093; prog[1] = 32'h0010_0113;
      prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_006F;
      wrap_exp[0] = 32'hE; wrap_exp[1] = 32'hB;
      wrap_exp[2] = 32'hC; wrap_exp[3] = 32'hD;

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_ir",    bus0.itcm_ifu_o_ir, 32'h0);
      check("rst_ready", 32'(bus0.ld_o_ready), 32'd0);
      check("rst_core",  32'(core0), 32'd0);
      check("rst_done",  32'(done0), 32'd0);
      rst_n = 1'b1;
      tick();

      // Load then fetch
      bus0.ld_i_start = 1'b1; tick(); bus0.ld_i_start = 1'b0;
      check("ld_ready_after_start", 32'(bus0.ld_o_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("core_held_in_load", 32'(core0), 32'd0);
         bus0.ld_i_valid = 1'b1; bus0.ld_i_data = prog[i];
         bus0.ld_i_last = (i == 3);
         tick();
      end
      bus0.ld_i_valid = 1'b0; bus0.ld_i_last = 1'b0;
      check("ld_done", 32'(done0), 32'd1);
      check("core_rel", 32'(core0), 32'd1);
      check("ready_off", 32'(bus0.ld_o_ready), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         bus0.ifu_flash_i_enable = 1'b1; bus0.ifu_flash_i_pc = 32'(i * 4);
         tick();
         check("fetch_word", bus0.itcm_ifu_o_ir, prog[i]);
      end

      // Hold and halfword alignment
      bus0.ifu_flash_i_pc = 32'h6; tick();
      bus0.ifu_flash_i_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("hold_word", bus0.itcm_ifu_o_ir, 32'h0010_0113);
         tick();
      end

      // Out of range
      bus0.ifu_flash_i_enable = 1'b1; bus0.ifu_flash_i_pc = 32'h0001_0000;
      tick();
      bus0.ifu_flash_i_enable = 1'b0;
      check("oor_nop", bus0.itcm_ifu_o_ir, 32'h0000_0013);
      check("oor_err", 32'(bus0.itcm_o_fetch_err), 32'd1);
      tick();
      check("oor_err_pulse", 32'(bus0.itcm_o_fetch_err), 32'd0);

      // Wrap on the 4-word instance, with start+run together and a restart
      bus1.ld_i_start = 1'b1; bus1.ld_i_run = 1'b1; tick();
      bus1.ld_i_start = 1'b0; bus1.ld_i_run = 1'b0;
      check("start_wins", 32'(bus1.ld_o_ready), 32'd1);
      bus1.ld_i_valid = 1'b1; bus1.ld_i_data = 32'h77; tick();
      bus1.ld_i_start = 1'b1; bus1.ld_i_data = 32'h55; tick();
      bus1.ld_i_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus1.ld_i_valid = 1'b1; bus1.ld_i_data = 32'(32'hA + i);
         bus1.ld_i_last = (i == 4);
         tick();
         if (i == 2) begin
            bus1.ld_i_valid = 1'b0; tick(); tick();
         end
      end
      bus1.ld_i_valid = 1'b0; bus1.ld_i_last = 1'b0;
      check("wrap_ovf", 32'(ovf1), 32'd1);
      check("wrap_done", 32'(done1), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         bus1.ifu_flash_i_enable = 1'b1; bus1.ifu_flash_i_pc = 32'(i * 4);
         tick();
         check("wrap_word", bus1.itcm_ifu_o_ir, wrap_exp[i]);
      end
      bus1.ifu_flash_i_pc = 32'h10; tick();
      bus1.ifu_flash_i_enable = 1'b0;
      check("wrap_oor", 32'(bus1.itcm_o_fetch_err), 32'd1);
      tick();

      // Reload from RUN; the concurrent fetch still completes
      bus0.ld_i_start = 1'b1; bus0.ifu_flash_i_enable = 1'b1;
      bus0.ifu_flash_i_pc = 32'h0;
      tick();
      bus0.ld_i_start = 1'b0; bus0.ifu_flash_i_enable = 1'b0;
      check("reload_core", 32'(core0), 32'd0);
      check("reload_ready", 32'(bus0.ld_o_ready), 32'd1);
      check("reload_done", 32'(done0), 32'd0);
      check("reload_fetch", bus0.itcm_ifu_o_ir, 32'h0000_0093);

      // Async reset after 2 of 4 beats
      bus0.ld_i_valid = 1'b1; bus0.ld_i_data = 32'h11; tick();
      bus0.ld_i_data = 32'h22; tick();
      bus0.ld_i_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_ir",    bus0.itcm_ifu_o_ir, 32'h0);
      check("arst_ready", 32'(bus0.ld_o_ready), 32'd0);
      check("arst_core",  32'(core0), 32'd0);
      check("arst_ovf1",  32'(ovf1), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      bus0.ifu_flash_i_enable = 1'b1; bus0.ifu_flash_i_pc = 32'h0;
      tick(); tick();
      check("idle_no_fetch", bus0.itcm_ifu_o_ir, 32'h0);

      // Run without load exposes the partial image
      bus0.ifu_flash_i_enable = 1'b0;
      bus0.ld_i_run = 1'b1; tick(); bus0.ld_i_run = 1'b0;
      check("run_core", 32'(core0), 32'd1);
      check("run_done", 32'(done0), 32'd0);
      bus0.ifu_flash_i_enable = 1'b1; bus0.ifu_flash_i_pc = 32'h0; tick();
      check("partial0", bus0.itcm_ifu_o_ir, 32'h11);
      bus0.ifu_flash_i_pc = 32'h4; tick();
      check("partial1", bus0.itcm_ifu_o_ir, 32'h22);
      bus0.ld_i_run = 1'b1; bus0.ifu_flash_i_enable = 1'b0; tick();
      bus0.ld_i_run = 1'b0;
      check("run_ignored", 32'(core0), 32'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
